// File: rtl/traffic_gen_buf_if.sv
// Flit output channel from a traffic generator toward a router local input port.
// Plain valid/ready handshake; the generator side is the master.
interface traffic_gen_buf_if #(
    parameter int DATA_W = 20
);
    logic [DATA_W-1:0] dataout;
    logic              out_valid;
    logic              out_ready;

    modport master (output dataout, output out_valid, input out_ready);
    modport slave  (input dataout, input out_valid, output out_ready);
endinterface

// File: rtl/traffic_gen_buf.sv
// Per-node NoC flit injector: builds {payload, dest} flits on the fly with a
// selectable destination pattern, optional inter-flit gap and burst repeat.
module traffic_gen_buf #(
    parameter int NODE_ID    = 2,
    parameter int NUM_NODES  = 16,
    parameter int DEST_W     = 4,
    parameter int PAY_W      = 16,
    parameter int PKT_COUNT  = 30,
    parameter int GAP        = 0,
    parameter int FIXED_DEST = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [1:0]               mode,
    input  logic                     repeat_en,
    input  logic                     restart,
    traffic_gen_buf_if.master        out_if,
    output logic                     done,
    output logic [7:0]               flit_cnt
);
    localparam int DATA_W = PAY_W + DEST_W;

    localparam logic [7:0]        NODE_BYTE    = 8'(NODE_ID);
    localparam logic [7:0]        LAST_IDX     = 8'(PKT_COUNT - 1);
    localparam logic [7:0]        GAP_LAST     = 8'(GAP - 1);
    localparam logic [DEST_W-1:0] RR_MAX       = DEST_W'(NUM_NODES - 1);
    localparam logic [DEST_W-1:0] DEST_FIXED   = DEST_W'(FIXED_DEST % NUM_NODES);
    localparam logic [DEST_W-1:0] DEST_TORNADO = DEST_W'((NODE_ID + NUM_NODES / 2 - 1) % NUM_NODES);
    localparam logic [DEST_W-1:0] DEST_COMPL   = DEST_W'(NUM_NODES - 1 - (NODE_ID % NUM_NODES));

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP, ST_DONE} state_t;

    state_t            state_reg;
    logic [1:0]        mode_reg;
    logic [7:0]        idx_reg;
    logic [DEST_W-1:0] rr_reg;
    logic [7:0]        gap_cnt_reg;
    logic [DATA_W-1:0] dataout_reg;
    logic              valid_reg;
    logic              done_reg;
    logic [7:0]        flit_cnt_reg;

    logic              last_flit;
    logic              xfer;
    logic [7:0]        idx_next;
    logic [DEST_W-1:0] rr_next;

    // Sequence number is the 1-based flit index, wrapping at 256.
    function automatic logic [DATA_W-1:0] make_flit(input logic [7:0]        idx,
                                                    input logic [DEST_W-1:0] rr,
                                                    input logic [1:0]        pat);
        logic [15:0]       pay16;
        logic [DEST_W-1:0] dest;
        pay16 = {NODE_BYTE, idx + 8'd1};
        case (pat)
            2'd0:    dest = DEST_FIXED;
            2'd1:    dest = rr;
            2'd2:    dest = DEST_TORNADO;
            default: dest = DEST_COMPL;
        endcase
        return {PAY_W'(pay16), dest};
    endfunction

    always_comb begin
        xfer      = valid_reg & out_if.out_ready;
        last_flit = (idx_reg == LAST_IDX);
        idx_next  = last_flit ? 8'd0 : idx_reg + 8'd1;
        if (last_flit || rr_reg == RR_MAX) rr_next = '0;
        else                               rr_next = rr_reg + DEST_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            mode_reg     <= 2'd0;
            idx_reg      <= 8'd0;
            rr_reg       <= '0;
            gap_cnt_reg  <= 8'd0;
            dataout_reg  <= '0;
            valid_reg    <= 1'b0;
            done_reg     <= 1'b0;
            flit_cnt_reg <= 8'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (enable) begin
                        mode_reg     <= mode;
                        idx_reg      <= 8'd0;
                        rr_reg       <= '0;
                        flit_cnt_reg <= 8'd0;
                        dataout_reg  <= make_flit(8'd0, '0, mode);
                        valid_reg    <= 1'b1;
                        state_reg    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (xfer) begin
                        idx_reg <= idx_next;
                        rr_reg  <= rr_next;
                        if (last_flit && !repeat_en) begin
                            flit_cnt_reg <= flit_cnt_reg + 8'd1;
                            valid_reg    <= 1'b0;
                            done_reg     <= 1'b1;
                            state_reg    <= ST_DONE;
                        end else begin
                            flit_cnt_reg <= last_flit ? 8'd0 : flit_cnt_reg + 8'd1;
                            if (GAP > 0) begin
                                valid_reg   <= 1'b0;
                                gap_cnt_reg <= 8'd0;
                                state_reg   <= ST_GAP;
                            end else if (enable) begin
                                dataout_reg <= make_flit(idx_next, rr_next, mode_reg);
                                valid_reg   <= 1'b1;
                            end else begin
                                valid_reg   <= 1'b0;
                            end
                        end
                    end else if (!valid_reg && enable) begin
                        // Paused between flits: idx/rr already point at the next flit.
                        dataout_reg <= make_flit(idx_reg, rr_reg, mode_reg);
                        valid_reg   <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        state_reg <= ST_SEND;
                        if (enable) begin
                            dataout_reg <= make_flit(idx_reg, rr_reg, mode_reg);
                            valid_reg   <= 1'b1;
                        end
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 8'd1;
                    end
                end
                ST_DONE: begin
                    if (restart) begin
                        done_reg     <= 1'b0;
                        flit_cnt_reg <= 8'd0;
                        state_reg    <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign out_if.dataout   = dataout_reg;
    assign out_if.out_valid = valid_reg;
    assign done             = done_reg;
    assign flit_cnt         = flit_cnt_reg;
endmodule

// File: tb/tb_traffic_gen_buf.sv
// Scenario bench for traffic_gen_buf: three instances (defaults, gap/round-robin,
// short repeat burst) checked against a scoreboard of expected flits.
module tb_traffic_gen_buf;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [19:0] exp_q[$];

    // Instance A: default parameters
    logic       a_en, a_rep, a_restart, a_done;
    logic [1:0] a_mode;
    logic [7:0] a_cnt;
    traffic_gen_buf_if #(.DATA_W(20)) a_if();
    traffic_gen_buf dut_a (
        .clk(clk), .rst(rst), .enable(a_en), .mode(a_mode), .repeat_en(a_rep),
        .restart(a_restart), .out_if(a_if), .done(a_done), .flit_cnt(a_cnt)
    );

    // Instance G: GAP=2, four nodes
    logic       g_en, g_rep, g_restart, g_done;
    logic [1:0] g_mode;
    logic [7:0] g_cnt;
    traffic_gen_buf_if #(.DATA_W(20)) g_if();
    traffic_gen_buf #(.NUM_NODES(4), .GAP(2)) dut_g (
        .clk(clk), .rst(rst), .enable(g_en), .mode(g_mode), .repeat_en(g_rep),
        .restart(g_restart), .out_if(g_if), .done(g_done), .flit_cnt(g_cnt)
    );

    // Instance R: three-flit bursts
    logic       r_en, r_rep, r_restart, r_done;
    logic [1:0] r_mode;
    logic [7:0] r_cnt;
    traffic_gen_buf_if #(.DATA_W(20)) r_if();
    traffic_gen_buf #(.PKT_COUNT(3)) dut_r (
        .clk(clk), .rst(rst), .enable(r_en), .mode(r_mode), .repeat_en(r_rep),
        .restart(r_restart), .out_if(r_if), .done(r_done), .flit_cnt(r_cnt)
    );

    // Expected flit for NODE_ID=2: {0x02, seq, dest}
    function automatic logic [19:0] exp_flit(input int seq, input int dest);
        logic [7:0] s;
        logic [3:0] d;
        s = 8'(seq);
        d = 4'(dest);
        return {8'h02, s, d};
    endfunction

    task automatic apply_reset();
        rst = 1'b0;
        a_en = 0; a_rep = 0; a_restart = 0; a_mode = 0; a_if.out_ready = 0;
        g_en = 0; g_rep = 0; g_restart = 0; g_mode = 0; g_if.out_ready = 0;
        r_en = 0; r_rep = 0; r_restart = 0; r_mode = 0; r_if.out_ready = 0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (a_if.out_valid !== 1'b0) begin failures++; $display("FAIL reset_a_valid: got %b want 0", a_if.out_valid); end
        checks++; if (a_if.dataout !== 20'h0) begin failures++; $display("FAIL reset_a_data: got %h want 00000", a_if.dataout); end
        checks++; if (a_done !== 1'b0) begin failures++; $display("FAIL reset_a_done: got %b want 0", a_done); end
        checks++; if (a_cnt !== 8'd0) begin failures++; $display("FAIL reset_a_cnt: got %0d want 0", a_cnt); end
        checks++; if (g_if.out_valid !== 1'b0) begin failures++; $display("FAIL reset_g_valid: got %b want 0", g_if.out_valid); end
        checks++; if (r_if.out_valid !== 1'b0 || r_done !== 1'b0) begin failures++; $display("FAIL reset_r: valid=%b done=%b want 0 0", r_if.out_valid, r_done); end
        repeat (3) @(negedge clk);
        checks++; if (a_if.out_valid !== 1'b0) begin failures++; $display("FAIL idle_no_enable: valid=%b want 0", a_if.out_valid); end
        $display("test_reset: done");
    endtask

    task automatic test_tornado();
        int got = 0;
        int cyc = 0;
        logic [19:0] exp;
        apply_reset();
        for (int i = 0; i < 30; i++) exp_q.push_back(exp_flit(i + 1, 9));
        a_mode = 2'd2; a_if.out_ready = 1'b1; a_en = 1'b1;
        @(negedge clk);
        while (got < 30 && cyc < 200) begin
            checks++;
            if (a_if.out_valid !== 1'b1) begin
                failures++; $display("FAIL tornado_valid: flit %0d valid=%b want 1", got, a_if.out_valid);
            end else begin
                exp = exp_q.pop_front();
                checks++;
                if (a_if.dataout !== exp) begin failures++; $display("FAIL tornado_flit %0d: got %h want %h", got, a_if.dataout, exp); end
                else $display("tornado flit %0d: %h", got, a_if.dataout);
                got++;
            end
            if (got == 10) a_mode = 2'd1;
            @(negedge clk);
            cyc++;
        end
        checks++; if (got != 30) begin failures++; $display("FAIL tornado_timeout: got %0d flits want 30", got); end
        checks++; if (a_done !== 1'b1) begin failures++; $display("FAIL tornado_done: got %b want 1", a_done); end
        checks++; if (a_cnt !== 8'd30) begin failures++; $display("FAIL tornado_cnt: got %0d want 30", a_cnt); end
        checks++; if (a_if.out_valid !== 1'b0) begin failures++; $display("FAIL tornado_valid_after: got %b want 0", a_if.out_valid); end
        repeat (3) @(negedge clk);
        checks++; if (a_if.out_valid !== 1'b0 || a_done !== 1'b1) begin failures++; $display("FAIL done_ignores_enable: valid=%b done=%b want 0 1", a_if.out_valid, a_done); end
        a_en = 1'b0;
    endtask

    task automatic test_backpressure();
        int got = 0;
        int cyc = 0;
        logic prev_stall = 1'b0;
        logic [19:0] prev_data = '0;
        logic rdy;
        logic [19:0] exp;
        apply_reset();
        for (int i = 0; i < 30; i++) exp_q.push_back(exp_flit(i + 1, 13));
        a_mode = 2'd3; a_en = 1'b1;
        while (got < 30 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (prev_stall) begin
                checks++;
                if (a_if.out_valid !== 1'b1 || a_if.dataout !== prev_data) begin
                    failures++; $display("FAIL bp_hold: valid=%b data=%h want 1 %h", a_if.out_valid, a_if.dataout, prev_data);
                end
            end
            rdy = ($urandom_range(0, 2) != 0);
            a_if.out_ready = rdy;
            if (a_if.out_valid === 1'b1 && rdy) begin
                exp = exp_q.pop_front();
                checks++;
                if (a_if.dataout !== exp) begin failures++; $display("FAIL bp_flit %0d: got %h want %h", got, a_if.dataout, exp); end
                else $display("backpressure flit %0d: %h", got, a_if.dataout);
                got++;
            end
            prev_stall = (a_if.out_valid === 1'b1) && !rdy;
            prev_data  = a_if.dataout;
        end
        @(negedge clk);
        checks++; if (got != 30) begin failures++; $display("FAIL bp_timeout: got %0d flits want 30", got); end
        checks++; if (a_done !== 1'b1 || a_cnt !== 8'd30) begin failures++; $display("FAIL bp_done: done=%b cnt=%0d want 1 30", a_done, a_cnt); end
        a_en = 1'b0;
    endtask

    task automatic test_gap_rr();
        int got = 0;
        int cyc = 0;
        int last_x = -1;
        logic [19:0] exp;
        apply_reset();
        for (int i = 0; i < 30; i++) exp_q.push_back(exp_flit(i + 1, i % 4));
        g_mode = 2'd1; g_if.out_ready = 1'b1; g_en = 1'b1;
        while (got < 30 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (g_if.out_valid === 1'b1) begin
                exp = exp_q.pop_front();
                checks++;
                if (g_if.dataout !== exp) begin failures++; $display("FAIL gap_flit %0d: got %h want %h", got, g_if.dataout, exp); end
                else $display("gap_rr flit %0d at cycle %0d: %h", got, cyc, g_if.dataout);
                checks++;
                if (last_x < 0 && cyc != 1) begin failures++; $display("FAIL gap_first_latency: cycle %0d want 1", cyc); end
                else if (last_x >= 0 && cyc - last_x != 3) begin failures++; $display("FAIL gap_spacing: %0d cycles want 3", cyc - last_x); end
                last_x = cyc;
                got++;
            end
        end
        @(negedge clk);
        checks++; if (got != 30) begin failures++; $display("FAIL gap_timeout: got %0d flits want 30", got); end
        checks++; if (g_done !== 1'b1 || g_cnt !== 8'd30) begin failures++; $display("FAIL gap_done: done=%b cnt=%0d want 1 30", g_done, g_cnt); end
        g_en = 1'b0;
    endtask

    task automatic test_repeat();
        int got = 0;
        int cyc = 0;
        logic [19:0] exp;
        apply_reset();
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 3; i++) exp_q.push_back(exp_flit(i + 1, 9));
        r_mode = 2'd2; r_rep = 1'b1; r_if.out_ready = 1'b1; r_en = 1'b1;
        while (got < 9 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            checks++;
            if (r_done !== 1'b0) begin failures++; $display("FAIL repeat_done_early: got %b want 0", r_done); end
            checks++;
            if (r_if.out_valid !== 1'b1) begin
                failures++; $display("FAIL repeat_bubble: flit %0d valid=%b want 1", got, r_if.out_valid);
            end else begin
                exp = exp_q.pop_front();
                checks++;
                if (r_if.dataout !== exp) begin failures++; $display("FAIL repeat_flit %0d: got %h want %h", got, r_if.dataout, exp); end
                else $display("repeat flit %0d: %h", got, r_if.dataout);
                got++;
                if (got == 4) begin
                    checks++;
                    if (r_cnt !== 8'd0) begin failures++; $display("FAIL repeat_cnt_wrap: got %0d want 0", r_cnt); end
                end
            end
            r_restart = (got == 5);
            if (got == 7) r_rep = 1'b0;
        end
        r_restart = 1'b0;
        @(negedge clk);
        checks++; if (got != 9) begin failures++; $display("FAIL repeat_timeout: got %0d flits want 9", got); end
        checks++; if (r_done !== 1'b1 || r_cnt !== 8'd3 || r_if.out_valid !== 1'b0) begin
            failures++; $display("FAIL repeat_end: done=%b cnt=%0d valid=%b want 1 3 0", r_done, r_cnt, r_if.out_valid);
        end
        repeat (2) @(negedge clk);
        checks++; if (r_if.out_valid !== 1'b0) begin failures++; $display("FAIL repeat_done_hold: valid=%b want 0", r_if.out_valid); end
        r_restart = 1'b1;
        @(negedge clk);
        r_restart = 1'b0;
        checks++; if (r_done !== 1'b0 || r_cnt !== 8'd0) begin failures++; $display("FAIL restart_clear: done=%b cnt=%0d want 0 0", r_done, r_cnt); end
        exp_q.push_back(exp_flit(1, 9));
        @(negedge clk);
        exp = exp_q.pop_front();
        checks++; if (r_if.out_valid !== 1'b1 || r_if.dataout !== exp) begin
            failures++; $display("FAIL restart_new_burst: valid=%b data=%h want 1 %h", r_if.out_valid, r_if.dataout, exp);
        end else $display("restart new burst flit: %h", r_if.dataout);
        r_en = 1'b0;
    endtask

    task automatic test_async_reset();
        int got = 0;
        int cyc = 0;
        logic [19:0] exp;
        apply_reset();
        for (int i = 0; i < 5; i++) exp_q.push_back(exp_flit(i + 1, 9));
        a_mode = 2'd2; a_if.out_ready = 1'b1; a_en = 1'b1;
        while (got < 5 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (a_if.out_valid === 1'b1) begin
                exp = exp_q.pop_front();
                checks++;
                if (a_if.dataout !== exp) begin failures++; $display("FAIL areset_flit %0d: got %h want %h", got, a_if.dataout, exp); end
                got++;
            end
        end
        @(posedge clk);
        #2;
        checks++; if (a_cnt !== 8'd5) begin failures++; $display("FAIL areset_pre_cnt: got %0d want 5", a_cnt); end
        rst = 1'b0;
        #1;
        checks++; if (a_if.out_valid !== 1'b0 || a_if.dataout !== 20'h0) begin
            failures++; $display("FAIL areset_outputs: valid=%b data=%h want 0 00000", a_if.out_valid, a_if.dataout);
        end
        checks++; if (a_cnt !== 8'd0 || a_done !== 1'b0) begin failures++; $display("FAIL areset_cnt: cnt=%0d done=%b want 0 0", a_cnt, a_done); end
        @(negedge clk);
        rst = 1'b1;
        exp_q.push_back(exp_flit(1, 9));
        @(negedge clk);
        exp = exp_q.pop_front();
        checks++; if (a_if.out_valid !== 1'b1 || a_if.dataout !== exp) begin
            failures++; $display("FAIL areset_restart: valid=%b data=%h want 1 %h", a_if.out_valid, a_if.dataout, exp);
        end else $display("async reset restart flit: %h", a_if.dataout);
        a_en = 1'b0;
    endtask

    task automatic test_enable_pause();
        logic [19:0] exp;
        apply_reset();
        exp_q.push_back(exp_flit(1, 0));
        exp_q.push_back(exp_flit(2, 0));
        a_mode = 2'd0; a_if.out_ready = 1'b0; a_en = 1'b1;
        @(negedge clk);
        exp = exp_q.pop_front();
        checks++; if (a_if.out_valid !== 1'b1 || a_if.dataout !== exp) begin
            failures++; $display("FAIL pause_first: valid=%b data=%h want 1 %h", a_if.out_valid, a_if.dataout, exp);
        end
        a_en = 1'b0;
        @(negedge clk);
        checks++; if (a_if.out_valid !== 1'b1 || a_if.dataout !== exp) begin
            failures++; $display("FAIL pause_withdrawn: valid=%b data=%h want 1 %h", a_if.out_valid, a_if.dataout, exp);
        end
        a_if.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (a_if.out_valid !== 1'b0) begin failures++; $display("FAIL pause_idle %0d: valid=%b want 0", i, a_if.out_valid); end
        end
        checks++; if (a_cnt !== 8'd1) begin failures++; $display("FAIL pause_cnt: got %0d want 1", a_cnt); end
        a_en = 1'b1;
        @(negedge clk);
        exp = exp_q.pop_front();
        checks++; if (a_if.out_valid !== 1'b1 || a_if.dataout !== exp) begin
            failures++; $display("FAIL pause_resume: valid=%b data=%h want 1 %h", a_if.out_valid, a_if.dataout, exp);
        end else $display("enable pause resume flit: %h", a_if.dataout);
        a_en = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        a_en = 0; a_rep = 0; a_restart = 0; a_mode = 0; a_if.out_ready = 0;
        g_en = 0; g_rep = 0; g_restart = 0; g_mode = 0; g_if.out_ready = 0;
        r_en = 0; r_rep = 0; r_restart = 0; r_mode = 0; r_if.out_ready = 0;
        test_reset();
        test_tornado();
        test_backpressure();
        test_gap_rr();
        test_repeat();
        test_async_reset();
        test_enable_pause();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/traffic_gen_buf.md
# traffic_gen_buf

Parametrised per-node flit injector for NoC traffic experiments. It replaces fixed-content, fixed-length injection ROMs with flits generated on the fly, in the form {payload, dest}. Destination patterns are selectable at run time, and the output uses a valid/ready handshake toward the router local input port. Burst length, inter-flit gap and node identity are parameters; a repeat mode supports continuous load runs.

## Interface
- NODE_ID, 2: this node's index; payload upper byte.
- NUM_NODES, 16: node count; destinations computed mod NUM_NODES; must be ≤ 2^DEST_W.
- DEST_W, 4: destination field width (flit LSBs).
- PAY_W, 16: payload field width; data width DATA_W = PAY_W + DEST_W.
- PKT_COUNT, 30: flits per burst, 1..255.
- GAP, 0: idle cycles forced after each accepted flit, 0..255.
- FIXED_DEST, 0: destination used in mode 0.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  level; starts a burst from IDLE and permits new flits.
- mode  in  2  pattern: 0 fixed, 1 round-robin, 2 tornado, 3 complement. Sampled on IDLE→SEND.
- repeat_en  in  1  sampled at the last transfer of a burst.
- restart  in  1  one-cycle pulse; DONE→IDLE.
- out_ready  in  1  downstream accept.
- dataout  out  DATA_W  flit {payload, dest}.
- out_valid  out  1  dataout valid.
- done  out  1  burst complete, non-repeat.
- flit_cnt  out  8  flits accepted in the current burst.

## Operation
- FSM states: IDLE, SEND, GAP, DONE.
- IDLE
  - enable=1: latch mode, clear index, load flit 0 into dataout, assert out_valid, go to SEND.
  - enable=0: stay.
- SEND: out_valid=1, dataout held stable until transfer (out_valid & out_ready at posedge).
- On transfer:
  - flit_cnt increments.
  - If this was flit PKT_COUNT-1:
    - repeat_en=1: index→0, flit_cnt→0, continue.
    - repeat_en=0: out_valid→0, done→1, go to DONE.
  - Otherwise index increments. With GAP=0 the next flit is loaded and valid the next cycle, provided enable=1. With GAP>0: out_valid→0, go to GAP.
- GAP: counts GAP cycles, then loads the next flit and returns to SEND.
- enable=0 in SEND after a transfer, or on GAP expiry: out_valid stays 0 and the FSM waits in SEND until enable=1.
- A flit already presented is never withdrawn: enable falling does not drop out_valid before its transfer.
- DONE: out_valid=0, done=1. restart → IDLE with done=0 and flit_cnt=0. enable is ignored in DONE.
- Flit for index i:
  - payload = {NODE_ID[7:0], seq[7:0]}, with seq = (i+1) mod 256, zero-extended/truncated to PAY_W.
  - dest, computed mod NUM_NODES, by mode:
    - mode 0: FIXED_DEST.
    - mode 1: i mod NUM_NODES, tracked with a wrapping counter; no divider.
    - mode 2: (NODE_ID + NUM_NODES/2 − 1) mod NUM_NODES.
    - mode 3: NUM_NODES − 1 − NODE_ID.

## Timing
- Reset values: dataout=0, out_valid=0, done=0, flit_cnt=0, state IDLE. Reset is asynchronous and takes effect mid-burst; no residual valid.
- Latency: enable sampled high in IDLE at edge k → out_valid=1 after edge k, so the first flit is visible in cycle k+1.
- Throughput: 1 flit/cycle with GAP=0 and out_ready=1. Otherwise 1 flit per GAP+1 cycles.
- out_ready low: dataout and out_valid hold indefinitely.
- done rises on the edge of the final transfer.
- restart and a transfer coincide: restart is ignored unless the FSM is in DONE.
- mode changes mid-burst have no effect until the next IDLE→SEND.

## Test plan
- Tornado burst.
  - Setup: defaults, mode=2, enable held, out_ready=1.
  - Required: 30 consecutive flits 0x02019, 0x02029, …, 0x021E9; done=1 the cycle after the last; flit_cnt=30.
- Backpressure.
  - Stimulus: out_ready toggles 1,0,0,1 pseudo-randomly.
  - Required: dataout stable while out_valid & !out_ready; no flit lost or duplicated; sequence 0x0201..0x021E intact.
- Gap and round-robin.
  - Setup: GAP=2, mode=1, NUM_NODES=4.
  - Required: out_valid pattern 1,0,0,1,…; dests 0,1,2,3,0,…; first flit 0x02010.
- Repeat.
  - Setup: PKT_COUNT=3, repeat_en=1.
  - Required: flits 0x02019, 0x02029, 0x02039, then 0x02019 again with no bubble; done stays 0.
  - Then drop repeat_en: DONE after the next flit 3; restart → a new burst on enable.
- Async reset mid-burst.
  - Stimulus: rst low after flit 5.
  - Required: outputs zero immediately. After release with enable=1, the burst restarts at 0x0201x.
- Enable pause.
  - Stimulus: enable low while a flit is pending.
  - Required: that flit completes; then out_valid=0 until enable returns, and the next flit is sequential.
